// File: rtl/fetch_seq_pkg.sv
// Shared sequencing definitions for the 9-bit-instruction processor.
// Controller and datapath import this so op codes and widths stay in step.
package fetch_seq_pkg;

  localparam int PC_W_DEF  = 16;
  localparam int IDX_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_BR_ABS = 3'd1,
    OP_BR_Z   = 3'd2,
    OP_BR_NZ  = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5,
    OP_HALT   = 3'd6
  } seq_op_t;

endpackage

// File: rtl/fetch_seq_ret_stack.sv
// Circular return-address LIFO; a push when full overwrites the oldest entry.
module ret_stack #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         reset_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_W-1:0]              push_data,
  output logic [PC_W-1:0]              top_data,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         ovf,
  output logic                         unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_m1;

  assign ptr_m1   = ptr - PTR_ONE;
  assign top_data = mem[ptr_m1];

  // Entries carry no reset; count guards every read.
  always_ff @(posedge CLK) begin
    if (push && !clr) mem[ptr] <= push_data;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (clr) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PTR_ONE;
      if (count == FULL) ovf <= 1'b1;
      else               count <= count + CNT_ONE;
    end else if (pop) begin
      if (count != '0) begin
        ptr   <= ptr_m1;
        count <= count - CNT_ONE;
      end else begin
        unf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Program-counter sequencer: PC, runtime relative/absolute target tables,
// return-address stack, and stall/halt/done handling.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter int              IDX_W     = IDX_W_DEF,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] LAST_PC   = '1
) (
  input  logic                        CLK,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        stall,
  input  seq_op_t                     op,
  input  logic [IDX_W-1:0]            idx,
  input  logic                        zero_flag,
  input  logic                        tbl_we,
  input  logic                        tbl_sel,
  input  logic [IDX_W-1:0]            tbl_waddr,
  input  logic [PC_W-1:0]             tbl_wdata,
  output logic [PC_W-1:0]             pc,
  output logic                        done,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_ovf,
  output logic                        ras_unf
);

  localparam int TBL_N = 2 ** IDX_W;

  logic [PC_W-1:0] rel_tbl [TBL_N];
  logic [PC_W-1:0] abs_tbl [TBL_N];

  logic [PC_W-1:0] nxt;
  logic [PC_W-1:0] pc_tgt;
  logic [PC_W-1:0] ras_top;
  logic            active;
  logic            adv;

  assign nxt    = pc + PC_W'(1);
  assign active = !start && !done && !stall;

  ret_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .clr       (start),
    .push      (active && (op == OP_CALL)),
    .pop       (active && (op == OP_RET)),
    .push_data (nxt),
    .top_data  (ras_top),
    .count     (ras_count),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

  // adv marks a plain fall-through, the only kind that can run off LAST_PC.
  always_comb begin
    adv    = 1'b0;
    pc_tgt = nxt;
    case (op)
      OP_BR_ABS: pc_tgt = abs_tbl[idx];
      OP_BR_Z:   if (zero_flag)  pc_tgt = pc + rel_tbl[idx]; else adv = 1'b1;
      OP_BR_NZ:  if (!zero_flag) pc_tgt = pc + rel_tbl[idx]; else adv = 1'b1;
      OP_CALL:   pc_tgt = abs_tbl[idx];
      OP_RET:    if (ras_count != '0) pc_tgt = ras_top; else adv = 1'b1;
      OP_HALT:   pc_tgt = pc;
      default:   adv = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      pc   <= '0;
      done <= 1'b0;
    end else if (start) begin
      pc   <= '0;
      done <= 1'b0;
    end else if (active) begin
      if (op == OP_HALT || (adv && pc == LAST_PC)) done <= 1'b1;
      else                                         pc   <= pc_tgt;
    end
  end

  // Reads above see the pre-edge contents, so a same-edge write lands next cycle.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TBL_N; i++) begin
        rel_tbl[i] <= '0;
        abs_tbl[i] <= '0;
      end
    end else if (tbl_we) begin
      if (tbl_sel) abs_tbl[tbl_waddr] <= tbl_wdata;
      else         rel_tbl[tbl_waddr] <= tbl_wdata;
    end
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Parametrised next-generation program-counter sequencer for the 9-bit-instruction processor. It replaces the fixed-parameter branch LUTs and bare PC logic in the datapath.
- Holds the PC and two runtime-programmable target tables (relative offsets, absolute addresses).
- Adds a return-address stack so subroutine call/return is real rather than a hard-wired target.
- Adds stall, halt and done handling. Sits between the controller/flags and the instruction ROM address input.

Parameters:
- PC_W, 16, PC and table entry width.
- IDX_W, 5, target-table index width; each table has 2**IDX_W entries.
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2).
- LAST_PC, 16'hFFFF, PC of the final instruction; advancing past it sets done.

Ports:
- CLK, input, 1, clock; all state changes on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, synchronous restart: PC to 0, RAS and done cleared; tables kept.
- stall, input, 1, hold PC and RAS this cycle.
- op, input, 3, seq_op_t sequencing operation for the current instruction.
- idx, input, IDX_W, target-table index for the current instruction.
- zero_flag, input, 1, registered ALU zero flag.
- tbl_we, input, 1, table write enable.
- tbl_sel, input, 1, table select for writes: 0 = relative, 1 = absolute.
- tbl_waddr, input, IDX_W, table write index.
- tbl_wdata, input, PC_W, table write data.
- pc, output, PC_W, current PC.
- done, output, 1, program finished; sticky until start or reset.
- ras_count, output, $clog2(RAS_DEPTH)+1, valid RAS entries.
- ras_ovf, output, 1, sticky: a call occurred with the stack full.
- ras_unf, output, 1, sticky: a return occurred with the stack empty.

Behaviour:
- reset_n low (async): pc=0, done=0, ras_count=0, ras_ovf=0, ras_unf=0, all table entries=0, RAS pointer=0.
- Per-edge priority: start > done hold > stall > op.
  - start: pc=0, ras_count=0, pointer=0, done=0, ovf/unf cleared.
  - done=1: pc and RAS hold.
  - stall=1: pc and RAS hold.
- Table writes are independent of the sequencing priority and happen on every edge with tbl_we=1, including during stall, done and start.
- A table read of an index written on the same edge returns the OLD value; the new value is visible the next cycle.
- Let nxt = pc+1, taken modulo 2**PC_W.
- OP_NEXT: pc=nxt.
- OP_BR_ABS: pc=abs_tbl[idx].
- OP_BR_Z: pc = zero_flag ? pc+rel_tbl[idx] : nxt.
- OP_BR_NZ: pc = !zero_flag ? pc+rel_tbl[idx] : nxt.
- Relative arithmetic: the table entry is two's-complement PC_W bits; the sum wraps modulo 2**PC_W with no error.
- OP_CALL: push nxt, pc=abs_tbl[idx].
  - If ras_count==RAS_DEPTH, the oldest entry is overwritten (circular), ras_count stays at RAS_DEPTH, ras_ovf=1, and the jump is still taken.
- OP_RET: if ras_count>0, pop into pc and decrement ras_count.
  - If empty: pc=nxt, ras_unf=1.
- OP_HALT: pc holds, done=1 on the next edge.
- Reserved code 7 behaves as OP_NEXT.
- Run-off: any non-branching advance from pc==LAST_PC sets done=1 and pc holds at LAST_PC.
  - This applies to OP_NEXT, untaken OP_BR_Z/OP_BR_NZ and empty OP_RET.
  - A taken branch, call or non-empty return from LAST_PC does not set done.
- Latency: pc updates one edge after the op is presented. Outputs are all registered; no combinational path from inputs to outputs.
- reset_n asserted mid-program: everything clears immediately, without waiting for CLK.

Decomposition:
- Shared package: seq_op_t enum with OP_NEXT=0, OP_BR_ABS=1, OP_BR_Z=2, OP_BR_NZ=3, OP_CALL=4, OP_RET=5, OP_HALT=6. Default PC_W and IDX_W constants also go there so the controller and datapath agree.
- One natural sub-module, ret_stack: a circular LIFO with push/pop/count/ovf/unf, parametrised by PC_W and RAS_DEPTH.
- Both target tables stay inline as register arrays.

Test Plan:
- Reset/start: hold reset_n=0, then release and issue OP_NEXT x3 -> pc 0,1,2,3. Assert start at pc=3 -> pc=0 and done=0 next edge; a table entry written earlier is still present.
- Relative branch: write rel_tbl[4]=-2 (16'hFFFE). At pc=10, op=OP_BR_NZ, zero_flag=0 -> pc=8. Repeat with zero_flag=1 -> pc=11. At pc=1, OP_BR_Z taken with offset -2 -> pc=16'hFFFF (wrap).
- Call/return nesting with RAS_DEPTH=4: abs_tbl[1]=100. Call at pc=5 -> pc=100, ras_count=1. Call at pc=100 -> pc=100, ras_count=2. OP_RET -> pc=101. OP_RET -> pc=6, ras_count=0. Another OP_RET -> pc=7, ras_unf=1.
- Overflow: 5 consecutive calls -> ras_ovf=1, ras_count=4. Four returns pop return addresses of calls 5,4,3,2; call 1's return address is lost.
- Stall and write collision: stall=1 with op=OP_BR_ABS for 3 cycles -> pc unchanged. Same-edge tbl_we to abs_tbl[idx] with new value 200 while an OP_BR_ABS reads that idx (old 50) -> pc=50.
- Done: LAST_PC=20, OP_NEXT at pc=20 -> done=1, pc stays 20 under further ops. Separately, OP_HALT at pc=7 -> done=1, pc=7.
